regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
- Shares the register file's single write port (WE3/A3/WD3) among NREQ writeback requesters: ALU, load unit and mul/div unit.
- Uses round-robin arbitration with a valid/ready handshake and registers the selected write for one cycle before it reaches the register file.
- Keeps a 32-entry pending-write scoreboard. Issue logic reserves a destination register, and the bit clears when the write commits. Decode queries the scoreboard to stall on RAW hazards.
- Sits between the execute/memory stages and the register file.

Parameters:
- NREQ, 3, number of writeback requesters (index 0 = ALU, 1 = LOAD, 2 = MULDIV); legal range 2..8.
- DATA_W, 32, write data width.
- ADDR_W, 5, register address width (32 registers).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- req_valid  input  NREQ  requester i has a write pending.
- req_addr  input  NREQ*ADDR_W  destination register of requester i; slice i = [i*ADDR_W +: ADDR_W].
- req_data  input  NREQ*DATA_W  write data of requester i; same slicing.
- req_ready  output  NREQ  one-hot grant; the transfer occurs when req_valid[i] && req_ready[i].
- rsv_valid  input  1  reserve a destination register at issue.
- rsv_addr  input  ADDR_W  register to reserve.
- q_addr1  input  ADDR_W  scoreboard query address 1.
- q_addr2  input  ADDR_W  scoreboard query address 2.
- q_busy1  output  1  register q_addr1 has a write pending (combinational).
- q_busy2  output  1  register q_addr2 has a write pending (combinational).
- WE3  output  1  register file write enable (registered).
- A3  output  ADDR_W  register file write address (registered).
- WD3  output  DATA_W  register file write data (registered).

Behaviour:
- Reset (rst low, asynchronous):
  - WE3=0, A3=0, WD3=0.
  - Scoreboard all 0.
  - RR pointer = NREQ-1, so requester 0 has top priority first.
  - req_ready is combinational and is 0 while no requester is valid.
- Arbitration (combinational):
  - Search starts at (ptr+1) mod NREQ, wraps around, and grants the first i with req_valid[i]=1.
  - req_ready is one-hot or zero, and never asserts for a requester that is not valid.
  - At most one grant per cycle.
- Pointer update: on a clock edge with a grant, ptr <= granted index; with no grant, ptr holds.
- Requester rule: once req_valid is asserted, addr/data stay stable until the handshake. The arbiter does not buffer ungranted requests.
- Write stage (1-cycle latency):
  - On an edge with grant g: A3 <= req_addr[g], WD3 <= req_data[g], WE3 <= (req_addr[g] != 0).
  - With no grant: WE3 <= 0; A3 and WD3 hold their values.
- Register $0: a write to address 0 is granted and handshaken normally and advances the pointer, but WE3 stays 0.
- Scoreboard, per register r, each edge:
  - set if rsv_valid && rsv_addr==r && r!=0;
  - else clear if WE3 && A3==r (commit);
  - else hold.
  - Simultaneous reserve and commit to the same register: set wins, because the new producer is still outstanding.
  - Reserving an already-busy register is legal; the bit stays 1. Issue logic is responsible for WAW ordering.
  - Entry 0 is constant 0.
- Queries: q_busyN = scoreboard[q_addrN], combinational. The query does not include a commit in the same cycle; it clears the cycle after WE3.
- Reset mid-operation: everything returns to reset values immediately, any pending write is dropped, and WE3 goes to 0 asynchronously.

Decomposition:
- Package mips_pkg: DATA_W, ADDR_W, NUM_REGS=32, REG_ZERO=0, and requester index constants REQ_ALU=0, REQ_LOAD=1, REQ_MULDIV=2.
- Sub-module rr_arbiter (parameter N): inputs clk, rst, req[N]; output gnt[N]. Contains the pointer, the combinational wrap-around search and the pointer update.
- The parent contains the data mux, the write-stage register and the scoreboard.

Test Plan:
- Reset check: hold rst=0 with random inputs -> WE3=0, A3=0, WD3=0, req_ready=000, q_busy1=q_busy2=0.
- Single write: req_valid=001, addr=5, data=0xDEADBEEF for one cycle -> req_ready=001 that cycle; next cycle WE3=1, A3=5, WD3=0xDEADBEEF; following cycle WE3=0.
- Round-robin order: all three requesters held valid (addrs 1, 2, 3) and each dropped after its handshake -> grants 0, 1, 2 on consecutive cycles; A3 sequence 1, 2, 3; a new req0 presented alongside req2 loses to req2.
- $0 suppression: requester 1 writes addr=0, data=0x1234 -> req_ready[1]=1 and the pointer advances to 1, but WE3 stays 0 the next cycle.
- Scoreboard: rsv_valid with addr=7 -> q_busy1 (q_addr1=7) is 1 from the next cycle. ALU then writes reg 7 -> busy clears the cycle after WE3=1. Separately, reserve reg 9 in the same cycle that WE3=1, A3=9 commits -> q_busy for 9 stays 1.
- Mid-operation reset: deassert rst while WE3=1 and scoreboard entries 4 and 7 are set -> WE3 drops immediately, scoreboard clears, and after release the first grant goes to requester 0.

Source files
------------

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants for the writeback path: register file geometry and requester indices.
package mips_pkg;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned ADDR_W     = 5;
  localparam int unsigned NUM_REGS   = 32;
  localparam int unsigned REG_ZERO   = 0;

  localparam int unsigned REQ_ALU    = 0;
  localparam int unsigned REQ_LOAD   = 1;
  localparam int unsigned REQ_MULDIV = 2;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback request bus: NREQ producers each offering one register write under valid/ready.
interface regfile_wb_arbiter_if #(
  parameter int unsigned NREQ   = 3,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
);

  logic [NREQ-1:0]        req_valid;
  logic [NREQ*ADDR_W-1:0] req_addr;
  logic [NREQ*DATA_W-1:0] req_data;
  logic [NREQ-1:0]        req_ready;

  modport master (
    output req_valid,
    output req_addr,
    output req_data,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_addr,
    input  req_data,
    output req_ready
  );

endinterface

// File: rtl/regfile_wb_arbiter_rr.sv
// Round-robin arbiter: one-hot grant searched from the slot after the last winner.
module rr_arbiter #(
  parameter int unsigned N = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt
);

  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] ptr_d;
  logic [PW-1:0] idx;

  // No grant while in reset: a handshake there would be silently dropped.
  always_comb begin
    gnt   = '0;
    ptr_d = ptr_q;
    idx   = '0;
    if (rst) begin
      for (int unsigned k = 1; k <= N; k++) begin
        idx = PW'((32'(ptr_q) + k) % N);
        if (req[idx] && (gnt == '0)) begin
          gnt[idx] = 1'b1;
          ptr_d    = idx;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q <= PW'(N - 1);
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for the register file write port plus the pending-write scoreboard.
module regfile_wb_arbiter #(
  parameter int unsigned NREQ   = 3,
  parameter int unsigned DATA_W = mips_pkg::DATA_W,
  parameter int unsigned ADDR_W = mips_pkg::ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst,
  regfile_wb_arbiter_if.slave   bus,
  input  logic                  rsv_valid,
  input  logic [ADDR_W-1:0]     rsv_addr,
  input  logic [ADDR_W-1:0]     q_addr1,
  input  logic [ADDR_W-1:0]     q_addr2,
  output logic                  q_busy1,
  output logic                  q_busy2,
  output logic                  WE3,
  output logic [ADDR_W-1:0]     A3,
  output logic [DATA_W-1:0]     WD3
);

  import mips_pkg::*;

  logic [NREQ-1:0]     gnt;
  logic                any_gnt;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_data;

  logic                we3_q, we3_d;
  logic [ADDR_W-1:0]   a3_q, a3_d;
  logic [DATA_W-1:0]   wd3_q, wd3_d;
  logic [NUM_REGS-1:0] sb_q, sb_d;

  rr_arbiter #(.N(NREQ)) u_rr (
    .clk (clk),
    .rst (rst),
    .req (bus.req_valid),
    .gnt (gnt)
  );

  assign bus.req_ready = gnt;

  // Grant is one-hot, so a plain overriding mux is enough.
  always_comb begin
    any_gnt  = |gnt;
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (gnt[i]) begin
        sel_addr = bus.req_addr[i*int'(ADDR_W) +: ADDR_W];
        sel_data = bus.req_data[i*int'(DATA_W) +: DATA_W];
      end
    end
  end

  // Writes to $0 still consume the grant but never assert the write enable.
  always_comb begin
    we3_d = any_gnt && (sel_addr != ADDR_W'(REG_ZERO));
    a3_d  = any_gnt ? sel_addr : a3_q;
    wd3_d = any_gnt ? sel_data : wd3_q;
  end

  // A fresh reservation beats a same-cycle commit: the newer producer is still in flight.
  always_comb begin
    sb_d = sb_q;
    for (int unsigned r = 1; r < NUM_REGS; r++) begin
      if (rsv_valid && (rsv_addr == ADDR_W'(r))) begin
        sb_d[r] = 1'b1;
      end else if (we3_q && (a3_q == ADDR_W'(r))) begin
        sb_d[r] = 1'b0;
      end
    end
    sb_d[REG_ZERO] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we3_q <= 1'b0;
      a3_q  <= '0;
      wd3_q <= '0;
      sb_q  <= '0;
    end else begin
      we3_q <= we3_d;
      a3_q  <= a3_d;
      wd3_q <= wd3_d;
      sb_q  <= sb_d;
    end
  end

  assign WE3     = we3_q;
  assign A3      = a3_q;
  assign WD3     = wd3_q;
  assign q_busy1 = sb_q[q_addr1];
  assign q_busy2 = sb_q[q_addr2];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: arbitration order, $0 suppression, scoreboard, resets.
module tb_regfile_wb_arbiter;

  localparam int unsigned NREQ   = 3;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;

  logic              clk;
  logic              rst;
  logic              rsv_valid;
  logic [ADDR_W-1:0] rsv_addr;
  logic [ADDR_W-1:0] q_addr1;
  logic [ADDR_W-1:0] q_addr2;
  logic              q_busy1;
  logic              q_busy2;
  logic              WE3;
  logic [ADDR_W-1:0] A3;
  logic [DATA_W-1:0] WD3;

  int n_cmp = 0;
  int n_bad = 0;

  regfile_wb_arbiter_if #(.NREQ(NREQ), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  regfile_wb_arbiter #(.NREQ(NREQ), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .rsv_valid (rsv_valid),
    .rsv_addr  (rsv_addr),
    .q_addr1   (q_addr1),
    .q_addr2   (q_addr2),
    .q_busy1   (q_busy1),
    .q_busy2   (q_busy2),
    .WE3       (WE3),
    .A3        (A3),
    .WD3       (WD3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    bus.req_addr[i*int'(ADDR_W) +: ADDR_W] = a;
    bus.req_data[i*int'(DATA_W) +: DATA_W] = d;
  endtask

  task automatic nedge();
    @(negedge clk);
  endtask

  task automatic pedge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset held with random activity on every input
    rst           = 1'b0;
    bus.req_valid = 3'($urandom);
    bus.req_addr  = 15'($urandom);
    bus.req_data  = {$urandom, $urandom, $urandom};
    rsv_valid     = 1'b1;
    rsv_addr      = 5'($urandom_range(1, 31));
    q_addr1       = rsv_addr;
    q_addr2       = 5'($urandom);
    pedge();
    pedge();
    chk("rst_we3", 64'(WE3), 64'(0));
    chk("rst_a3", 64'(A3), 64'(0));
    chk("rst_wd3", 64'(WD3), 64'(0));
    chk("rst_ready", 64'(bus.req_ready), 64'(0));
    chk("rst_busy1", 64'(q_busy1), 64'(0));
    chk("rst_busy2", 64'(q_busy2), 64'(0));

    nedge();
    rst           = 1'b1;
    bus.req_valid = '0;
    bus.req_addr  = '0;
    bus.req_data  = '0;
    rsv_valid     = 1'b0;
    rsv_addr      = '0;
    q_addr1       = '0;
    q_addr2       = '0;
    #1 chk("idle_ready", 64'(bus.req_ready), 64'(0));

    // Single ALU write
    nedge();
    bus.req_valid = 3'b001;
    set_req(0, 5'd5, 32'hDEADBEEF);
    #1 chk("single_ready", 64'(bus.req_ready), 64'(3'b001));
    pedge();
    chk("single_we3", 64'(WE3), 64'(1));
    chk("single_a3", 64'(A3), 64'(5));
    chk("single_wd3", 64'(WD3), 64'(32'hDEADBEEF));
    nedge();
    bus.req_valid = 3'b000;
    pedge();
    chk("single_we3_off", 64'(WE3), 64'(0));
    chk("single_a3_hold", 64'(A3), 64'(5));

    // Reset pulse so the pointer starts at NREQ-1 again
    nedge();
    rst = 1'b0;
    nedge();
    rst = 1'b1;

    // Round-robin: all three valid, each drops after its handshake
    bus.req_valid = 3'b111;
    set_req(0, 5'd1, 32'h11);
    set_req(1, 5'd2, 32'h22);
    set_req(2, 5'd3, 32'h33);
    #1 chk("rr_gnt0", 64'(bus.req_ready), 64'(3'b001));
    pedge();
    chk("rr_a3_1", 64'(A3), 64'(1));
    nedge();
    bus.req_valid = 3'b110;
    #1 chk("rr_gnt1", 64'(bus.req_ready), 64'(3'b010));
    pedge();
    chk("rr_a3_2", 64'(A3), 64'(2));
    chk("rr_wd3_2", 64'(WD3), 64'(32'h22));
    nedge();
    bus.req_valid = 3'b101;
    set_req(0, 5'd4, 32'h44);
    #1 chk("rr_gnt2_over_0", 64'(bus.req_ready), 64'(3'b100));
    pedge();
    chk("rr_a3_3", 64'(A3), 64'(3));
    nedge();
    bus.req_valid = 3'b001;
    #1 chk("rr_gnt0_again", 64'(bus.req_ready), 64'(3'b001));
    pedge();
    chk("rr_a3_4", 64'(A3), 64'(4));
    chk("rr_wd3_4", 64'(WD3), 64'(32'h44));
    nedge();
    bus.req_valid = 3'b000;

    // Write to $0 from the load unit: handshake happens, WE3 stays low
    nedge();
    bus.req_valid = 3'b010;
    set_req(1, 5'd0, 32'h1234);
    #1 chk("zero_ready", 64'(bus.req_ready), 64'(3'b010));
    pedge();
    chk("zero_we3", 64'(WE3), 64'(0));
    nedge();
    bus.req_valid = 3'b011;
    set_req(0, 5'd6, 32'h66);
    #1 chk("zero_ptr_moved", 64'(bus.req_ready), 64'(3'b001));
    pedge();
    chk("zero_next_we3", 64'(WE3), 64'(1));
    chk("zero_next_a3", 64'(A3), 64'(6));
    nedge();
    bus.req_valid = 3'b000;

    // Scoreboard: reserve 7, then commit it
    nedge();
    rsv_valid = 1'b1;
    rsv_addr  = 5'd7;
    q_addr1   = 5'd7;
    q_addr2   = 5'd9;
    #1 chk("sb7_not_yet", 64'(q_busy1), 64'(0));
    pedge();
    chk("sb7_set", 64'(q_busy1), 64'(1));
    nedge();
    rsv_valid     = 1'b0;
    bus.req_valid = 3'b001;
    set_req(0, 5'd7, 32'h77);
    #1 chk("sb7_ready", 64'(bus.req_ready), 64'(3'b001));
    pedge();
    chk("sb7_we3", 64'(WE3), 64'(1));
    chk("sb7_busy_during_we", 64'(q_busy1), 64'(1));
    nedge();
    bus.req_valid = 3'b000;
    pedge();
    chk("sb7_cleared", 64'(q_busy1), 64'(0));

    // Scoreboard: re-reserve 9 in the cycle its commit lands
    nedge();
    rsv_valid = 1'b1;
    rsv_addr  = 5'd9;
    pedge();
    chk("sb9_set", 64'(q_busy2), 64'(1));
    nedge();
    rsv_valid     = 1'b0;
    bus.req_valid = 3'b001;
    set_req(0, 5'd9, 32'h99);
    pedge();
    chk("sb9_we3", 64'(WE3), 64'(1));
    chk("sb9_a3", 64'(A3), 64'(9));
    nedge();
    bus.req_valid = 3'b000;
    rsv_valid     = 1'b1;
    rsv_addr      = 5'd9;
    pedge();
    chk("sb9_set_wins", 64'(q_busy2), 64'(1));
    nedge();
    rsv_valid = 1'b0;
    pedge();
    chk("sb9_still_busy", 64'(q_busy2), 64'(1));

    // Mid-operation reset with WE3 high and entries 4, 7 pending
    nedge();
    rsv_valid = 1'b1;
    rsv_addr  = 5'd4;
    nedge();
    rsv_addr  = 5'd7;
    nedge();
    rsv_valid     = 1'b0;
    q_addr1       = 5'd7;
    q_addr2       = 5'd4;
    bus.req_valid = 3'b010;
    set_req(1, 5'd12, 32'hC0FFEE);
    #1 chk("mr_ready", 64'(bus.req_ready), 64'(3'b010));
    pedge();
    chk("mr_we3_pre", 64'(WE3), 64'(1));
    chk("mr_busy7_pre", 64'(q_busy1), 64'(1));
    chk("mr_busy4_pre", 64'(q_busy2), 64'(1));
    #2 rst = 1'b0;
    #1;
    chk("mr_we3_async", 64'(WE3), 64'(0));
    chk("mr_a3", 64'(A3), 64'(0));
    chk("mr_wd3", 64'(WD3), 64'(0));
    chk("mr_busy7", 64'(q_busy1), 64'(0));
    chk("mr_busy4", 64'(q_busy2), 64'(0));
    chk("mr_ready_in_rst", 64'(bus.req_ready), 64'(0));
    nedge();
    rst           = 1'b1;
    bus.req_valid = 3'b111;
    set_req(0, 5'd10, 32'hA0);
    set_req(1, 5'd11, 32'hB0);
    set_req(2, 5'd13, 32'hD0);
    #1 chk("mr_first_gnt", 64'(bus.req_ready), 64'(3'b001));
    pedge();
    chk("mr_first_a3", 64'(A3), 64'(10));
    nedge();
    bus.req_valid = 3'b000;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
